// File: rtl/golay_pkg.sv
// Golay(24,12) decoder constants: B matrix rows, B-transpose rows, unit vectors, error-count width.
// Shared by the BTS stage and the error locator so both use one matrix definition.
package golay_pkg;

  localparam int NERR_W = 2;

  localparam logic [11:0] BR1  = 12'h7FF;
  localparam logic [11:0] BR2  = 12'hEE2;
  localparam logic [11:0] BR3  = 12'hDC5;
  localparam logic [11:0] BR4  = 12'hB8B;
  localparam logic [11:0] BR5  = 12'hF16;
  localparam logic [11:0] BR6  = 12'hE2D;
  localparam logic [11:0] BR7  = 12'hC5B;
  localparam logic [11:0] BR8  = 12'h8B7;
  localparam logic [11:0] BR9  = 12'h96E;
  localparam logic [11:0] BR10 = 12'hADC;
  localparam logic [11:0] BR11 = 12'hDB8;
  localparam logic [11:0] BR12 = 12'hB71;

  // B is symmetric, so each transpose row equals the matching B row.
  localparam logic [11:0] BTR1  = 12'h7FF;
  localparam logic [11:0] BTR2  = 12'hEE2;
  localparam logic [11:0] BTR3  = 12'hDC5;
  localparam logic [11:0] BTR4  = 12'hB8B;
  localparam logic [11:0] BTR5  = 12'hF16;
  localparam logic [11:0] BTR6  = 12'hE2D;
  localparam logic [11:0] BTR7  = 12'hC5B;
  localparam logic [11:0] BTR8  = 12'h8B7;
  localparam logic [11:0] BTR9  = 12'h96E;
  localparam logic [11:0] BTR10 = 12'hADC;
  localparam logic [11:0] BTR11 = 12'hDB8;
  localparam logic [11:0] BTR12 = 12'hB71;

  localparam logic [11:0] BR [1:12] = '{BR1, BR2, BR3, BR4, BR5, BR6,
                                        BR7, BR8, BR9, BR10, BR11, BR12};
  localparam logic [11:0] BTR [1:12] = '{BTR1, BTR2, BTR3, BTR4, BTR5, BTR6,
                                         BTR7, BTR8, BTR9, BTR10, BTR11, BTR12};

  // u_1 = 800 ... u_12 = 001; index 0 yields zero.
  function automatic logic [11:0] unit_vec(input logic [3:0] idx);
    unit_vec = 12'h800 >> (idx - 4'd1);
  endfunction

endpackage

// File: rtl/golay_err_corr_wt12.sv
// Combinational 12-bit popcount with weight<=2 and weight<=3 flags.
// Zero latency; no flow control.
module golay_wt12 (
  input  logic [11:0] v,
  output logic [3:0]  wt,
  output logic        le2,
  output logic        le3
);

  always_comb begin
    wt = '0;
    for (int i = 0; i < 12; i++) begin
      wt = wt + {3'b000, v[i]};
    end
  end

  assign le2 = (wt <= 4'd2);
  assign le3 = (wt <= 4'd3);

endmodule

// File: rtl/golay_err_corr.sv
// Golay(24,12) error locator/corrector with saturating health counters.
// Fixed 3-cycle latency, one word per clock, no backpressure.
module golay_err_corr
  import golay_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              S_VLD,
  input  logic [11:0]       S,
  input  logic [23:0]       RCV,
  input  logic [11:0]       BTS,
  input  logic              CLR_CNT,
  output logic              DOUT_VLD,
  output logic [11:0]       DOUT,
  output logic [NERR_W-1:0] NERR,
  output logic              UNCORR,
  output logic [CNT_W-1:0]  CORR_CNT,
  output logic [CNT_W-1:0]  UNCORR_CNT
);

  logic unused_rcv_par;
  assign unused_rcv_par = ^RCV[11:0];

  // P1: syndrome and received data
  logic        p1_vld_q, p1_vld_d;
  logic [11:0] p1_s_q, p1_s_d;
  logic [11:0] p1_dat_q, p1_dat_d;

  always_comb begin
    p1_vld_d = S_VLD;
    p1_s_d   = S_VLD ? S : p1_s_q;
    p1_dat_d = S_VLD ? RCV[23:12] : p1_dat_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      p1_vld_q <= 1'b0;
      p1_s_q   <= '0;
      p1_dat_q <= '0;
    end else begin
      p1_vld_q <= p1_vld_d;
      p1_s_q   <= p1_s_d;
      p1_dat_q <= p1_dat_d;
    end
  end

  // Weight units: S, BTS, and the 12+12 candidate sums
  logic [3:0]  s_wt, b_wt;
  logic        s_le3, b_le3, unused_s_le2, unused_b_le2;
  logic [3:0]  sc_wt [1:12];
  logic [3:0]  bc_wt [1:12];
  logic [12:1] sc_le2, bc_le2, unused_sc_le3, unused_bc_le3;

  golay_wt12 u_wt_s (.v(p1_s_q), .wt(s_wt), .le2(unused_s_le2), .le3(s_le3));
  golay_wt12 u_wt_b (.v(BTS),    .wt(b_wt), .le2(unused_b_le2), .le3(b_le3));

  for (genvar g = 1; g <= 12; g++) begin : g_cand
    golay_wt12 u_wt_sc (.v(p1_s_q ^ BR[g]), .wt(sc_wt[g]), .le2(sc_le2[g]),
                        .le3(unused_sc_le3[g]));
    golay_wt12 u_wt_bc (.v(BTS ^ BTR[g]),   .wt(bc_wt[g]), .le2(bc_le2[g]),
                        .le3(unused_bc_le3[g]));
  end

  // P2: weights, test flags and the lowest-index candidate of tests 2 and 4
  logic        p2_vld_q, p2_vld_d;
  logic [11:0] p2_dat_q, p2_dat_d;
  logic [11:0] p2_bts_q, p2_bts_d;
  logic [3:0]  p2_s_wt_q, p2_s_wt_d, p2_b_wt_q, p2_b_wt_d;
  logic        p2_s_le3_q, p2_s_le3_d, p2_b_le3_q, p2_b_le3_d;
  logic        p2_s_hit_q, p2_s_hit_d, p2_b_hit_q, p2_b_hit_d;
  logic [3:0]  p2_s_idx_q, p2_s_idx_d;
  logic [3:0]  p2_sc_wt_q, p2_sc_wt_d, p2_bc_wt_q, p2_bc_wt_d;
  logic [11:0] p2_bc_dat_q, p2_bc_dat_d;

  always_comb begin
    p2_vld_d    = p1_vld_q;
    p2_dat_d    = p1_dat_q;
    p2_bts_d    = BTS;
    p2_s_wt_d   = s_wt;
    p2_b_wt_d   = b_wt;
    p2_s_le3_d  = s_le3;
    p2_b_le3_d  = b_le3;
    p2_s_hit_d  = 1'b0;
    p2_s_idx_d  = '0;
    p2_sc_wt_d  = '0;
    p2_b_hit_d  = 1'b0;
    p2_bc_wt_d  = '0;
    p2_bc_dat_d = '0;
    // Walk downwards so the lowest matching index is the one left standing.
    for (int i = 12; i >= 1; i--) begin
      if (sc_le2[i]) begin
        p2_s_hit_d = 1'b1;
        p2_s_idx_d = 4'(i);
        p2_sc_wt_d = sc_wt[i];
      end
      if (bc_le2[i]) begin
        p2_b_hit_d  = 1'b1;
        p2_bc_wt_d  = bc_wt[i];
        p2_bc_dat_d = BTS ^ BTR[i];
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      p2_vld_q    <= 1'b0;
      p2_dat_q    <= '0;
      p2_bts_q    <= '0;
      p2_s_wt_q   <= '0;
      p2_b_wt_q   <= '0;
      p2_s_le3_q  <= 1'b0;
      p2_b_le3_q  <= 1'b0;
      p2_s_hit_q  <= 1'b0;
      p2_b_hit_q  <= 1'b0;
      p2_s_idx_q  <= '0;
      p2_sc_wt_q  <= '0;
      p2_bc_wt_q  <= '0;
      p2_bc_dat_q <= '0;
    end else begin
      p2_vld_q    <= p2_vld_d;
      p2_dat_q    <= p2_dat_d;
      p2_bts_q    <= p2_bts_d;
      p2_s_wt_q   <= p2_s_wt_d;
      p2_b_wt_q   <= p2_b_wt_d;
      p2_s_le3_q  <= p2_s_le3_d;
      p2_b_le3_q  <= p2_b_le3_d;
      p2_s_hit_q  <= p2_s_hit_d;
      p2_b_hit_q  <= p2_b_hit_d;
      p2_s_idx_q  <= p2_s_idx_d;
      p2_sc_wt_q  <= p2_sc_wt_d;
      p2_bc_wt_q  <= p2_bc_wt_d;
      p2_bc_dat_q <= p2_bc_dat_d;
    end
  end

  // P3: priority select, correction and output hold
  logic [11:0]       e_dat;
  logic [3:0]        n_sum;
  logic              unc;
  logic              dout_vld_q, dout_vld_d, uncorr_q, uncorr_d;
  logic [11:0]       dout_q, dout_d;
  logic [NERR_W-1:0] nerr_q, nerr_d;

  always_comb begin
    e_dat = '0;
    n_sum = '0;
    unc   = 1'b0;
    if (p2_s_le3_q) begin
      n_sum = p2_s_wt_q;
    end else if (p2_s_hit_q) begin
      e_dat = unit_vec(p2_s_idx_q);
      n_sum = p2_sc_wt_q + 4'd1;
    end else if (p2_b_le3_q) begin
      e_dat = p2_bts_q;
      n_sum = p2_b_wt_q;
    end else if (p2_b_hit_q) begin
      e_dat = p2_bc_dat_q;
      n_sum = p2_bc_wt_q + 4'd1;
    end else begin
      unc = 1'b1;
    end

    dout_vld_d = p2_vld_q;
    dout_d     = dout_q;
    nerr_d     = nerr_q;
    uncorr_d   = uncorr_q;
    if (p2_vld_q) begin
      dout_d   = p2_dat_q ^ e_dat;
      nerr_d   = NERR_W'(n_sum);
      uncorr_d = unc;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dout_vld_q <= 1'b0;
      dout_q     <= '0;
      nerr_q     <= '0;
      uncorr_q   <= 1'b0;
    end else begin
      dout_vld_q <= dout_vld_d;
      dout_q     <= dout_d;
      nerr_q     <= nerr_d;
      uncorr_q   <= uncorr_d;
    end
  end

  // Health counters
  logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d, uncorr_cnt_q, uncorr_cnt_d;

  always_comb begin
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    if (CLR_CNT) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end else if (dout_vld_q) begin
      if (nerr_q != '0 && corr_cnt_q != '1)
        corr_cnt_d = corr_cnt_q + CNT_W'(1);
      if (uncorr_q && uncorr_cnt_q != '1)
        uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign DOUT_VLD   = dout_vld_q;
  assign DOUT       = dout_q;
  assign NERR       = nerr_q;
  assign UNCORR     = uncorr_q;
  assign CORR_CNT   = corr_cnt_q;
  assign UNCORR_CNT = uncorr_cnt_q;

endmodule

// File: tb/tb_golay_err_corr.sv
// Bench for golay_err_corr: builds codewords, injects known error patterns and
// expects the original data back (weight <= 3) or an uncorrectable flag (weight 4).
module tb_golay_err_corr;

  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RST, S_VLD, CLR_CNT;
  logic [11:0]   S, BTS;
  logic [23:0]   RCV;
  logic          DOUT_VLD, UNCORR;
  logic [11:0]   DOUT;
  logic [1:0]    NERR;
  logic [CW-1:0] CORR_CNT, UNCORR_CNT;

  golay_err_corr #(.CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .S_VLD(S_VLD), .S(S), .RCV(RCV), .BTS(BTS),
    .CLR_CNT(CLR_CNT), .DOUT_VLD(DOUT_VLD), .DOUT(DOUT), .NERR(NERR),
    .UNCORR(UNCORR), .CORR_CNT(CORR_CNT), .UNCORR_CNT(UNCORR_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          due;
    logic [11:0] dout;
    logic [1:0]  nerr;
    logic        unc;
  } exp_t;

  exp_t        expq[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [11:0] pend_bts = '0;
  logic [11:0] last_dout = '0;
  logic [1:0]  last_nerr = '0;
  logic        last_unc = 1'b0;
  int          m_corr = 0;
  int          m_unc = 0;

  logic [11:0] brow [12] = '{12'h7FF, 12'hEE2, 12'hDC5, 12'hB8B, 12'hF16, 12'hE2D,
                             12'hC5B, 12'h8B7, 12'h96E, 12'hADC, 12'hDB8, 12'hB71};

  // Parity of a data word: XOR of B rows selected by data bits, MSB = row 1.
  function automatic logic [11:0] enc(input logic [11:0] d);
    logic [11:0] r = '0;
    for (int i = 0; i < 12; i++) if (d[11-i]) r ^= brow[i];
    return r;
  endfunction

  // B-transpose times x: XOR of B columns selected by bits of x.
  function automatic logic [11:0] bt(input logic [11:0] x);
    logic [11:0] r = '0;
    for (int i = 0; i < 12; i++)
      if (x[11-i])
        for (int j = 0; j < 12; j++) r[11-j] ^= brow[j][11-i];
    return r;
  endfunction

  function automatic logic [23:0] randerr(input int w);
    logic [23:0] e = '0;
    while ($countones(e) < w) e[$urandom_range(23, 0)] = 1'b1;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  // One clock: drive inputs, check this cycle's outputs, update the counter model.
  task automatic step(input logic vld, input logic [23:0] rcv, input logic clr,
                      input logic [11:0] edout, input logic [1:0] enerr, input logic eunc);
    logic [11:0] s;
    exp_t e;
    s = enc(rcv[23:12]) ^ rcv[11:0];
    S_VLD = vld; S = s; RCV = rcv; BTS = pend_bts; CLR_CNT = clr;
    pend_bts = bt(s);
    if (vld) expq.push_back('{cyc + 3, edout, enerr, eunc});
    chk("corr_cnt", 32'(CORR_CNT), 32'(m_corr));
    chk("uncorr_cnt", 32'(UNCORR_CNT), 32'(m_unc));
    if (expq.size() > 0 && expq[0].due == cyc) begin
      e = expq.pop_front();
      chk("dout_vld", 32'(DOUT_VLD), 32'd1);
      last_dout = e.dout; last_nerr = e.nerr; last_unc = e.unc;
      if (clr) begin
        m_corr = 0; m_unc = 0;
      end else begin
        if (e.nerr != 0 && m_corr < CMAX) m_corr++;
        if (e.unc && m_unc < CMAX) m_unc++;
      end
    end else begin
      chk("dout_vld_idle", 32'(DOUT_VLD), 32'd0);
      if (clr) begin m_corr = 0; m_unc = 0; end
    end
    chk("dout", 32'(DOUT), 32'(last_dout));
    chk("nerr", 32'(NERR), 32'(last_nerr));
    chk("uncorr", 32'(UNCORR), 32'(last_unc));
    @(posedge CLK); #1;
    cyc++;
  endtask

  task automatic word(input logic [11:0] d, input logic [23:0] err, input logic clr);
    logic [23:0] rcv;
    int w;
    rcv = {d, enc(d)} ^ err;
    w = $countones(err);
    if (w <= 3) step(1'b1, rcv, clr, d, 2'(w), 1'b0);
    else        step(1'b1, rcv, clr, rcv[23:12], 2'd0, 1'b1);
  endtask

  task automatic idle(input int n, input logic clr);
    for (int k = 0; k < n; k++) step(1'b0, 24'h0, clr, 12'h0, 2'd0, 1'b0);
  endtask

  initial begin
    RST = 1'b1; S_VLD = 1'b0; S = '0; RCV = '0; BTS = '0; CLR_CNT = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_vld", 32'(DOUT_VLD), 32'd0);
    chk("rst_dout", 32'(DOUT), 32'd0);
    RST = 1'b0;
    idle(2, 1'b0);

    // Directed patterns
    word(12'hABC, 24'h000000, 1'b0);   // clean
    word(12'h5A3, 24'h000007, 1'b0);   // 3 parity bits
    word(12'h123, 24'h800000, 1'b0);   // data MSB
    word(12'h9E4, 24'hF00000, 1'b0);   // 4 data bits: uncorrectable
    word(12'h0F0, 24'h000800, 1'b0);   // parity MSB
    word(12'h777, 24'h030000, 1'b0);   // 2 data bits
    idle(4, 1'b0);

    // Back-to-back stream of correctable words; counter saturates at CMAX
    for (int n = 0; n < 100; n++) word(12'($urandom), randerr($urandom_range(3, 0)), 1'b0);
    idle(4, 1'b0);
    word(12'($urandom), randerr(1), 1'b0);
    idle(4, 1'b0);

    // Clear coincident with an increment
    word(12'($urandom), randerr(2), 1'b0);
    idle(2, 1'b0);
    idle(1, 1'b1);
    idle(2, 1'b0);

    // Mixed weights 0..4 with random gaps
    for (int n = 0; n < 60; n++) begin
      word(12'($urandom), randerr($urandom_range(4, 0)), 1'b0);
      if ($urandom_range(3, 0) == 0) idle(1, 1'b0);
    end
    idle(4, 1'b0);

    // Reset with two words in flight
    word(12'h3C5, randerr(1), 1'b0);
    word(12'hC3A, randerr(4), 1'b0);
    RST = 1'b1;
    #2;
    expq.delete();
    m_corr = 0; m_unc = 0;
    last_dout = '0; last_nerr = '0; last_unc = 1'b0;
    pend_bts = '0;
    @(posedge CLK); #1;
    cyc++;
    RST = 1'b0;
    idle(6, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

endmodule
